draw_sequencer: RTL and testbench
=================================

Name: draw_sequencer

Overview:
Per-frame render scheduler that owns the single VGA plot port (x/y/colour/plot).
- After reset: clears the 160x120 screen, then runs the map tile drawer once by holding its counter enable for the full tile sweep.
- On each frame tick: sequences four object passes (erase tank 1, erase tank 2, draw tank 1, draw tank 2) through the shared object drawer with a start/done handshake.
- Multiplexes the active source onto the plot bus and flags missed frame ticks.

Parameters:
SCREEN_W, 160, clear sweep width (x = 0..SCREEN_W-1)
SCREEN_H, 120, clear sweep height (y = 0..SCREEN_H-1)
MAP_TAIL, 48, cycles map enable stays high counting from the first map_finish cycle (one tile's pixel count)
BG_COLOUR, 3'b000, colour driven during CLEAR
MAP_COLOUR, 3'b111, colour driven during map drawing

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle frame pulse
map_redraw  in  1  one-cycle request to redraw the map (no clear)
map_finish  in  1  map drawer last-tile flag
mx  in  8  map drawer pixel x
my  in  7  map drawer pixel y
map_counter_enable  out  1  map drawer counter enable
obj_start  out  1  one-cycle start pulse to object drawer
obj_sel  out  2  pass index: 0 erase T1, 1 erase T2, 2 draw T1, 3 draw T2
ox  in  8  object drawer pixel x
oy  in  7  object drawer pixel y
ocolour  in  3  object drawer colour
oplot  in  1  object drawer write strobe
odone  in  1  object drawer pass complete (one-cycle pulse)
vga_x  out  8  plot x
vga_y  out  7  plot y
vga_colour  out  3  plot colour
vga_plot  out  1  plot write enable
busy  out  1  high in every state except IDLE
frame_overrun  out  1  sticky missed-tick flag

Behaviour:
- Registers: state, cx[7:0], cy[6:0], tail[5:0], slot[1:0], tick_pending, frame_overrun. All asynchronously reset.
- Reset values: state=CLEAR, counters 0, slot 0, pending 0, overrun 0.
- While reset is high: vga_plot=0, map_counter_enable=0, obj_start=0, busy=1.
- States: CLEAR, MAP, IDLE, OBJ_START, OBJ_WAIT.
- CLEAR:
  - vga_plot=1, vga_x=cx, vga_y=cy, colour=BG_COLOUR.
  - cx increments each cycle; at cx=SCREEN_W-1, cx wraps to 0 and cy increments.
  - At (SCREEN_W-1, SCREEN_H-1): go to MAP, counters cleared. Exactly 19200 plot cycles.
- MAP:
  - map_counter_enable=1; vga_plot=1 in the same cycles, vga_x=mx, vga_y=my, colour=MAP_COLOUR.
  - Zero latency: mx/my are combinational from the drawer counters.
  - tail increments on each cycle map_finish=1. On the cycle where tail=MAP_TAIL-1 with map_finish=1, go to IDLE.
  - Enable is high for exactly 256*48 = 12288 consecutive cycles.
  - Enable drops the cycle after the last pixel, which returns the drawer counters to 0.
- IDLE:
  - vga_plot=0, enable=0, vga_x/vga_y/vga_colour=0.
  - Priority: map_redraw > tick_pending/frame_tick.
  - map_redraw: go to MAP, tail=0. A frame_tick in the same cycle sets tick_pending.
  - frame_tick or tick_pending: go to OBJ_START, slot=0, clear pending.
- OBJ_START: obj_start=1 for one cycle, obj_sel=slot, vga_plot=0; next state OBJ_WAIT.
- OBJ_WAIT:
  - vga_x=ox, vga_y=oy, vga_colour=ocolour, vga_plot=oplot.
  - odone: if slot=3, go to IDLE; else slot+1 and go to OBJ_START.
  - oplot together with odone in the same cycle is still plotted.
  - odone seen in OBJ_START or IDLE is ignored.
- obj_sel holds slot in OBJ_START and OBJ_WAIT, and 0 elsewhere.
- Frame ticks during CLEAR and the initial MAP are ignored and do not set overrun.
- After the first entry to IDLE, a tick while busy:
  - sets tick_pending if it is clear;
  - if tick_pending is already set, sets frame_overrun and drops the tick.
- frame_overrun clears only on reset.
- map_redraw while busy is ignored.
- Reset mid-operation: everything returns to CLEAR immediately (asynchronous); the whole screen is redrawn after release.

Test Plan:
- Release reset -> 19200 plot cycles with colour 000 covering (0,0)..(159,119) in raster order, then map_counter_enable high for exactly 12288 cycles, then busy=0.
- In MAP, drive map_finish high from cycle 12240 -> enable falls after cycle 12287; vga_plot mirrors enable; colour 111 throughout.
- In IDLE, frame_tick -> obj_start pulses with obj_sel 0,1,2,3, each one cycle after the previous odone; oplot/ox/oy/ocolour pass to the VGA bus; IDLE after the 4th odone.
- Two ticks during one object sequence -> first is pending and runs immediately after return to IDLE; a third tick sets frame_overrun=1, which stays set.
- map_redraw and frame_tick in the same IDLE cycle -> 12288-cycle map pass first, then the object sequence runs; frame_overrun stays 0.
- Assert reset during OBJ_WAIT with oplot=1 -> vga_plot=0 and obj_start=0 at once; after release, CLEAR restarts at (0,0).

Source files
------------

// File: rtl/draw_sequencer.sv
// Per-frame render scheduler: screen clear, map sweep, then four object passes per frame tick on one VGA plot port.
// Map pixels pass to the plot bus with zero latency; the object drawer is paced by a start/done handshake, and extra frame ticks queue one deep.
module draw_sequencer #(
  parameter int         SCREEN_W   = 160,
  parameter int         SCREEN_H   = 120,
  parameter int         MAP_TAIL   = 48,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter logic [2:0] MAP_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       map_redraw,
  input  logic       map_finish,
  input  logic [7:0] mx,
  input  logic [6:0] my,
  output logic       map_counter_enable,
  output logic       obj_start,
  output logic [1:0] obj_sel,
  input  logic [7:0] ox,
  input  logic [6:0] oy,
  input  logic [2:0] ocolour,
  input  logic       oplot,
  input  logic       odone,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_overrun
);

  typedef enum logic [2:0] {S_CLEAR, S_MAP, S_IDLE, S_OBJ_START, S_OBJ_WAIT} state_t;

  localparam logic [7:0] X_LAST    = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST    = 7'(SCREEN_H - 1);
  localparam logic [5:0] TAIL_LAST = 6'(MAP_TAIL - 1);

  state_t     state, state_nxt;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [5:0] tail;
  logic [1:0] slot;
  logic       tick_pending;
  logic       init_done;

  logic clear_last, tail_last;
  assign clear_last = (cx == X_LAST) && (cy == Y_LAST);
  assign tail_last  = map_finish && (tail == TAIL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:     if (clear_last) state_nxt = S_MAP;
      S_MAP:       if (tail_last) state_nxt = S_IDLE;
      S_IDLE: begin
        if (map_redraw)                      state_nxt = S_MAP;
        else if (frame_tick || tick_pending) state_nxt = S_OBJ_START;
      end
      S_OBJ_START: state_nxt = S_OBJ_WAIT;
      S_OBJ_WAIT:  if (odone) state_nxt = (slot == 2'd3) ? S_IDLE : S_OBJ_START;
      default:     state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx   <= '0;
      cy   <= '0;
      tail <= '0;
      slot <= '0;
    end else begin
      if (state == S_CLEAR) begin
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= (cy == Y_LAST) ? 7'd0 : cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end else begin
        cx <= '0;
        cy <= '0;
      end

      if (state != S_MAP)  tail <= '0;
      else if (map_finish) tail <= tail_last ? 6'd0 : tail + 6'd1;

      if (state == S_IDLE)                                    slot <= '0;
      else if (state == S_OBJ_WAIT && odone && slot != 2'd3)  slot <= slot + 2'd1;
    end
  end

  // One tick may wait behind a busy sequencer; a second one is dropped and flagged.
  // Ticks before the first arrival in IDLE are not frames we were expected to serve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_pending  <= 1'b0;
      frame_overrun <= 1'b0;
      init_done     <= 1'b0;
    end else if (state == S_IDLE) begin
      init_done <= 1'b1;
      if (map_redraw) begin
        if (frame_tick) begin
          if (tick_pending) frame_overrun <= 1'b1;
          else              tick_pending  <= 1'b1;
        end
      end else if (frame_tick || tick_pending) begin
        tick_pending <= frame_tick && tick_pending;
      end
    end else if (init_done && frame_tick) begin
      if (tick_pending) frame_overrun <= 1'b1;
      else              tick_pending  <= 1'b1;
    end
  end

  always_comb begin
    map_counter_enable = 1'b0;
    obj_start          = 1'b0;
    obj_sel            = 2'd0;
    vga_x              = '0;
    vga_y              = '0;
    vga_colour         = '0;
    vga_plot           = 1'b0;
    busy               = (state != S_IDLE);
    case (state)
      S_CLEAR: begin
        vga_x      = cx;
        vga_y      = cy;
        vga_colour = BG_COLOUR;
        vga_plot   = 1'b1;
      end
      S_MAP: begin
        map_counter_enable = 1'b1;
        vga_x              = mx;
        vga_y              = my;
        vga_colour         = MAP_COLOUR;
        vga_plot           = 1'b1;
      end
      S_OBJ_START: begin
        obj_start = 1'b1;
        obj_sel   = slot;
      end
      S_OBJ_WAIT: begin
        obj_sel    = slot;
        vga_x      = ox;
        vga_y      = oy;
        vga_colour = ocolour;
        vga_plot   = oplot;
      end
      default: ;
    endcase
    // Strobes must be quiet the instant reset is asserted, before state settles.
    if (reset) begin
      vga_plot           = 1'b0;
      map_counter_enable = 1'b0;
      obj_start          = 1'b0;
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: clear raster, map sweep, object passes, tick queuing and mid-pass reset.
module tb_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, map_redraw, map_finish;
  logic [7:0] mx, ox, vga_x;
  logic [6:0] my, oy, vga_y;
  logic [2:0] ocolour, vga_colour;
  logic       oplot, odone;
  logic       map_counter_enable, obj_start, vga_plot, busy, frame_overrun;
  logic [1:0] obj_sel;

  int total = 0;
  int bad   = 0;

  draw_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .map_redraw(map_redraw),
    .map_finish(map_finish), .mx(mx), .my(my), .map_counter_enable(map_counter_enable),
    .obj_start(obj_start), .obj_sel(obj_sel), .ox(ox), .oy(oy), .ocolour(ocolour),
    .oplot(oplot), .odone(odone), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    frame_tick = 1'b0; map_redraw = 1'b0; map_finish = 1'b0;
    odone = 1'b0; oplot = 1'b0; mx = '0; my = '0; ox = '0; oy = '0; ocolour = '0;
  endtask

  // 12288-cycle map pass; map_finish rises at cycle 12240, optional tick at cycle tick_at
  task automatic run_map(input string tag, input int tick_at);
    int errs = 0;
    for (int j = 0; j < 12288; j++) begin
      @(negedge clk);
      map_finish = (j >= 12240);
      mx = 8'(j % 160);
      my = 7'(j % 120);
      frame_tick = (j == tick_at);
      #1;
      if (!(vga_plot === 1'b1 && map_counter_enable === 1'b1 && busy === 1'b1 &&
            vga_x === mx && vga_y === my && vga_colour === 3'b111)) errs++;
    end
    @(negedge clk);
    clr_in();
    #1;
    chk({tag, "_cycle_errs"}, errs, 0);
    chk({tag, "_en_after"}, map_counter_enable, 0);
    chk({tag, "_plot_after"}, vga_plot, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic expect_start(input logic [1:0] sel, input logic stray_done);
    @(negedge clk);
    clr_in();
    odone = stray_done;
    #1;
    chk("os_start", obj_start, 1);
    chk("os_sel", obj_sel, sel);
    chk("os_plot", vga_plot, 0);
  endtask

  task automatic obj_wait(input logic [1:0] sel, input int n, input logic tick);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      clr_in();
      ox = 8'(20 * sel + k + 1);
      oy = 7'(k + 3);
      ocolour = 3'(sel + k + 1);
      oplot = (k == n - 1) ? 1'b1 : k[0];
      odone = (k == n - 1);
      frame_tick = tick && (k == 0);
      #1;
      chk("ow_x", vga_x, ox);
      chk("ow_y", vga_y, oy);
      chk("ow_col", vga_colour, ocolour);
      chk("ow_plot", vga_plot, oplot);
      chk("ow_sel", obj_sel, sel);
      chk("ow_start", obj_start, 0);
    end
  endtask

  task automatic run_seq(input int tick_a, input int tick_b);
    for (int p = 0; p < 4; p++) begin
      expect_start(2'(p), p == 2);
      obj_wait(2'(p), 2 + p, (p == tick_a) || (p == tick_b));
    end
  endtask

  task automatic idle_check(input string tag, input logic exp_ovr);
    @(negedge clk);
    clr_in();
    #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, obj_start, 0);
    chk({tag, "_ovr"}, frame_overrun, exp_ovr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d", total);
    bad++;
    $display("test done: total=%0d bad=%0d", total + 1, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_errs;
    int first_bad;
    reset = 1'b1;
    clr_in();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_plot", vga_plot, 0);
    chk("rst_en", map_counter_enable, 0);
    chk("rst_start", obj_start, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ovr", frame_overrun, 0);

    // screen clear in raster order; tick at pixel 500 must be ignored
    reset = 1'b0;
    clr_errs = 0;
    first_bad = -1;
    for (int i = 0; i < 19200; i++) begin
      if (i > 0) begin
        @(negedge clk);
        frame_tick = (i == 500);
      end
      #1;
      if (!(vga_plot === 1'b1 && vga_x === 8'(i % 160) && vga_y === 7'(i / 160) &&
            vga_colour === 3'b000 && busy === 1'b1 && map_counter_enable === 1'b0)) begin
        clr_errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk("clear_cycle_errs", clr_errs, 0);
    chk("clear_first_bad", first_bad, -1);

    run_map("map_init", 100);
    idle_check("post_map", 1'b0);

    // stray odone in IDLE does nothing
    @(negedge clk);
    odone = 1'b1;
    #1;
    chk("idle_done_busy", busy, 0);
    idle_check("idle_done", 1'b0);

    // plain frame: four passes, back to IDLE, nothing pending
    @(negedge clk);
    frame_tick = 1'b1;
    #1;
    chk("tick_sel_idle", obj_sel, 0);
    run_seq(-1, -1);
    idle_check("seq1_end", 1'b0);
    idle_check("seq1_nopend", 1'b0);

    // redraw and tick together: map first, then the queued frame
    @(negedge clk);
    map_redraw = 1'b1;
    frame_tick = 1'b1;
    #1;
    chk("redraw_busy0", busy, 0);
    run_map("map_redraw", -1);
    chk("redraw_ovr", frame_overrun, 0);
    run_seq(-1, -1);
    idle_check("seq2_end", 1'b0);
    idle_check("seq2_nopend", 1'b0);

    // one tick queued behind a frame, then two more in one frame overrun
    @(negedge clk);
    frame_tick = 1'b1;
    #1;
    run_seq(0, -1);
    @(negedge clk);
    clr_in();
    #1;
    chk("pend_idle_busy", busy, 0);
    chk("pend_no_ovr", frame_overrun, 0);
    run_seq(0, 1);
    @(negedge clk);
    clr_in();
    #1;
    chk("ovr_set", frame_overrun, 1);
    run_seq(-1, -1);
    idle_check("ovr_sticky", 1'b1);
    idle_check("ovr_drained", 1'b1);

    // reset in the middle of an object pass
    @(negedge clk);
    frame_tick = 1'b1;
    #1;
    expect_start(2'd0, 1'b0);
    @(negedge clk);
    oplot = 1'b1;
    ox = 8'd33;
    #1;
    chk("mid_plot", vga_plot, 1);
    reset = 1'b1;
    #1;
    chk("arst_plot", vga_plot, 0);
    chk("arst_start", obj_start, 0);
    chk("arst_busy", busy, 1);
    chk("arst_ovr", frame_overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    clr_in();
    #1;
    chk("restart_x", vga_x, 0);
    chk("restart_y", vga_y, 0);
    chk("restart_plot", vga_plot, 1);
    chk("restart_col", vga_colour, 0);
    @(negedge clk);
    #1;
    chk("restart_x1", vga_x, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
